// File: rtl/test_sequencer.sv
// test_sequencer: loads a test program into the core's instruction memory, runs the core
// out of reset and reports pass/fail/timeout when the exit ecall (x17 == EXIT_CODE) appears.
module test_sequencer #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned IMEM_DEPTH = 1024,
    parameter int unsigned TIMEOUT    = 100000,
    parameter int unsigned EXIT_CODE  = 93,
    localparam int unsigned AW        = $clog2(IMEM_DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_last,
    output logic             imem_we,
    output logic [AW-1:0]    imem_addr,
    output logic [WIDTH-1:0] imem_wdata,
    output logic             cpu_reset,
    input  logic [WIDTH-1:0] reg_a7,
    input  logic [WIDTH-1:0] reg_gp,
    output logic             busy,
    output logic             done,
    output logic             passed,
    output logic             timed_out,
    output logic [WIDTH-1:0] cycle_count
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StCpuRst,
        StRun,
        StDone
    } state_e;

    localparam logic [AW-1:0]    LastAddr   = AW'(IMEM_DEPTH - 1);
    localparam logic [WIDTH-1:0] ExitVal    = WIDTH'(EXIT_CODE);
    localparam logic [WIDTH-1:0] TimeoutVal = WIDTH'(TIMEOUT - 1);
    localparam logic [WIDTH-1:0] GpPass     = WIDTH'(1);

    state_e           state_q, state_d;
    logic [AW-1:0]    wcnt_q, wcnt_d;
    logic             rst_cnt_q, rst_cnt_d;
    logic [WIDTH-1:0] cycle_count_q, cycle_count_d;
    logic             done_q, done_d;
    logic             passed_q, passed_d;
    logic             timed_out_q, timed_out_d;

    logic accept;
    logic exit_hit;
    logic timeout_hit;

    // Handshake and memory write port; ready depends only on the registered state.
    always_comb begin
        load_ready  = (state_q == StLoad);
        accept      = load_valid & load_ready;
        imem_we     = accept;
        imem_addr   = wcnt_q;
        imem_wdata  = load_data;
        cpu_reset   = (state_q != StRun);
        busy        = (state_q == StLoad) || (state_q == StCpuRst) || (state_q == StRun);
        done        = done_q;
        passed      = passed_q;
        timed_out   = timed_out_q;
        cycle_count = cycle_count_q;
        exit_hit    = (reg_a7 == ExitVal);
        timeout_hit = (cycle_count_q == TimeoutVal);
    end

    // Next-state logic for the run controller.
    always_comb begin
        state_d       = state_q;
        wcnt_d        = wcnt_q;
        rst_cnt_d     = rst_cnt_q;
        cycle_count_d = cycle_count_q;
        done_d        = done_q;
        passed_d      = passed_q;
        timed_out_d   = timed_out_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d       = StLoad;
                    wcnt_d        = '0;
                    cycle_count_d = '0;
                    done_d        = 1'b0;
                    passed_d      = 1'b0;
                    timed_out_d   = 1'b0;
                end
            end
            StLoad: begin
                if (accept) begin
                    wcnt_d = wcnt_q + AW'(1);
                    // Stop at the last flagged word or at the end of memory.
                    if (load_last || (wcnt_q == LastAddr)) begin
                        state_d   = StCpuRst;
                        rst_cnt_d = 1'b0;
                    end
                end
            end
            StCpuRst: begin
                // Two cycles of core reset flush stale register state.
                rst_cnt_d = 1'b1;
                if (rst_cnt_q) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                cycle_count_d = cycle_count_q + WIDTH'(1);
                // Exit takes priority over a coincident timeout.
                if (exit_hit) begin
                    state_d     = StDone;
                    done_d      = 1'b1;
                    passed_d    = (reg_gp == GpPass);
                    timed_out_d = 1'b0;
                end else if (timeout_hit) begin
                    state_d     = StDone;
                    done_d      = 1'b1;
                    passed_d    = 1'b0;
                    timed_out_d = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and registered outputs; synchronous reset overrides everything including start.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= StIdle;
            wcnt_q        <= '0;
            rst_cnt_q     <= 1'b0;
            cycle_count_q <= '0;
            done_q        <= 1'b0;
            passed_q      <= 1'b0;
            timed_out_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            wcnt_q        <= wcnt_d;
            rst_cnt_q     <= rst_cnt_d;
            cycle_count_q <= cycle_count_d;
            done_q        <= done_d;
            passed_q      <= passed_d;
            timed_out_q   <= timed_out_d;
        end
    end

endmodule
